// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   AddrWidth     : PC / fetch address width (8 bits, byte addressed)
//   InstrWidth    : instruction word width (32 bits)
//   fetch_state_e : fetch sequencer states
//   is_word_aligned() : true when an address sits on a 32-bit word boundary
package fetch_pkg;

  localparam int unsigned AddrWidth  = 8;
  localparam int unsigned InstrWidth = 32;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StDrop
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [AddrWidth-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Decode-side output register of the fetch stage: holds one fetched instruction
// and its PC, presented to decode with a valid flag.
//   clk_i, rst_ni : clock, asynchronous active-low reset (all outputs cleared)
//   load_i        : capture pc_i / instr_i and raise valid_o
//   clear_i       : drop valid_o (wins over load_i); pc_o / instr_o keep their value
//   pc_i, instr_i : PC and instruction word to capture
//   valid_o, pc_o, instr_o : registered decode-side outputs
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [AddrWidth-1:0]  pc_i,
  input  logic [InstrWidth-1:0] instr_i,
  output logic                  valid_o,
  output logic [AddrWidth-1:0]  pc_o,
  output logic [InstrWidth-1:0] instr_o
);

  logic                  valid_q, valid_d;
  logic [AddrWidth-1:0]  pc_q, pc_d;
  logic [InstrWidth-1:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/pc_fetch.sv
// Single-outstanding instruction fetch sequencer.
// Issues one request at a time to instruction memory, waits for its response,
// hands the instruction to decode over a valid/ready handshake, then advances
// the PC using an external adder (pc_out -> next_pc). A flush redirects the PC
// at any time; a response belonging to a request issued before the flush is
// discarded.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   pc_out / next_pc      : current PC to the external adder / its result
//   flush / flush_pc      : redirect request and target
//   imem_req / imem_addr  : fetch request and address (held until imem_gnt)
//   imem_gnt              : request accepted
//   imem_rvalid/imem_rdata: response strobe and instruction word
//   if_valid / if_ready   : handshake to decode; if_pc / if_instr carry the payload
//   misalign_err          : sticky misaligned-fetch flag
//
// Build option: define PC_FETCH_ALIGN_CHECK_EN to refuse fetching from a PC with
// pc[1:0] != 0 (misalign_err raised, no request until a flush to an aligned PC).
// Without it misalign_err is tied low.
module pc_fetch
  import fetch_pkg::*;
#(
  parameter logic [AddrWidth-1:0] RESET_PC = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [AddrWidth-1:0]  pc_out,
  input  logic [AddrWidth-1:0]  next_pc,
  input  logic                  flush,
  input  logic [AddrWidth-1:0]  flush_pc,
  output logic                  imem_req,
  output logic [AddrWidth-1:0]  imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [InstrWidth-1:0] imem_rdata,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [AddrWidth-1:0]  if_pc,
  output logic [InstrWidth-1:0] if_instr,
  output logic                  misalign_err
);

  fetch_state_e         state_q, state_d;
  logic [AddrWidth-1:0] pc_q, pc_d;
  logic [AddrWidth-1:0] req_addr_q, req_addr_d;
  // Set when a flush hits a request that is still waiting for its grant: the
  // request must complete unchanged, and its response is then thrown away.
  logic                 drop_pend_q, drop_pend_d;
  logic                 misalign_q;

  logic gnt;
  logic reenter;
  logic enter_req;
  logic out_load;
  logic out_clear;

  // A misaligned REQ never shows the request, so a grant there is meaningless.
  assign imem_req  = (state_q == StReq) && !misalign_q;
  assign imem_addr = req_addr_q;
  assign gnt       = imem_req && imem_gnt;
  assign pc_out    = pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_pend_d = drop_pend_q;
    out_load    = 1'b0;
    out_clear   = 1'b0;

    case (state_q)
      StIdle: begin
        state_d = StReq;
        if (flush) pc_d = flush_pc;
      end

      StReq: begin
        if (flush) begin
          pc_d = flush_pc;
          if (misalign_q) begin
            // Nothing in flight: simply restart the request at the new PC.
            state_d = StReq;
          end else if (gnt) begin
            state_d = StDrop;
          end else begin
            drop_pend_d = 1'b1;
          end
        end else if (gnt) begin
          state_d = drop_pend_q ? StDrop : StWait;
        end
      end

      StWait: begin
        if (flush) begin
          pc_d    = flush_pc;
          state_d = imem_rvalid ? StReq : StDrop;
        end else if (imem_rvalid) begin
          out_load = 1'b1;
          pc_d     = next_pc;
          state_d  = StHold;
        end
      end

      StHold: begin
        if (flush) begin
          pc_d    = flush_pc;
          state_d = StReq;
        end else if (if_valid && if_ready) begin
          out_clear = 1'b1;
          state_d   = StReq;
        end
      end

      StDrop: begin
        if (flush) pc_d = flush_pc;
        // The stale response is consumed even when a flush lands on the same
        // edge; staying here would wait for a response that never comes.
        if (imem_rvalid) state_d = StReq;
      end

      default: state_d = StIdle;
    endcase

    if (flush) out_clear = 1'b1;
    if ((state_q == StReq) && (state_d != StReq)) drop_pend_d = 1'b0;
  end

  // The fetch address is captured from the PC as it will be on REQ entry, so a
  // flush that moves the FSM into REQ fetches from the flush target directly.
  assign reenter    = (state_q == StReq) && misalign_q && flush;
  assign enter_req  = (state_d == StReq) && ((state_q != StReq) || reenter);
  assign req_addr_d = enter_req ? pc_d : req_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      drop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      drop_pend_q <= drop_pend_d;
    end
  end

`ifdef PC_FETCH_ALIGN_CHECK_EN
  logic misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (enter_req) begin
      misalign_d = !is_word_aligned(pc_d);
    end else if (flush) begin
      misalign_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  assign misalign_q = 1'b0;
`endif

  assign misalign_err = misalign_q;

  fetch_out_reg u_out_reg (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (out_load),
    .clear_i (out_clear),
    .pc_i    (pc_q),
    .instr_i (imem_rdata),
    .valid_o (if_valid),
    .pc_o    (if_pc),
    .instr_o (if_instr)
  );

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: a responder models instruction memory, the
// expected decode stream is queued at each grant and checked by a monitor.
module tb_pc_fetch;

  localparam logic [7:0] ResetPc = 8'h00;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pc_out;
  logic [7:0]  next_pc;
  logic        flush;
  logic [7:0]  flush_pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [7:0]  if_pc;
  logic [31:0] if_instr;
  logic        misalign_err;

  // External PC adder.
  assign next_pc = pc_out + 8'd4;

  pc_fetch #(
    .RESET_PC (ResetPc)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_out       (pc_out),
    .next_pc      (next_pc),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .misalign_err (misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks = 0;
  int          errors = 0;
  int          hs_cnt = 0;
  logic [31:0] mem [256];
  logic [7:0]  exp_q [$];
  logic [7:0]  model_pc;
  bit          stale_req;
  bit          pending;
  int          dly;
  logic [7:0]  pend_addr;
  int          gnt_pct, max_dly, fixed_dly, ready_pct, spur_pct;
  bit          use_ovr;
  logic [31:0] ovr_data;
  bit          stale_after_rst;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Redirect: everything not yet handed to decode is lost, and a request still
  // waiting for its grant will have its response discarded.
  task automatic model_flush(input logic [7:0] tgt);
    flush     = 1'b1;
    flush_pc  = tgt;
    stale_req = stale_req | (imem_req & ~imem_gnt);
    exp_q.delete();
    model_pc  = tgt;
  endtask

  // Advance one clock and drive the inputs for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (!rst_n) begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      return;
    end
    if (imem_rvalid && pending) pending = 1'b0;
    if (imem_gnt) begin
      pending = 1'b1;
      dly     = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(max_dly, 0));
    end
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pending) begin
      if (dly == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = use_ovr ? ovr_data : mem[pend_addr];
        use_ovr     = 1'b0;
      end else begin
        dly--;
      end
    end else if (stale_after_rst || ($urandom_range(99, 0) < spur_pct)) begin
      imem_rvalid     = 1'b1;
      stale_after_rst = 1'b0;
    end
    if (!pending && imem_req && ($urandom_range(99, 0) < gnt_pct)) begin
      imem_gnt  = 1'b1;
      pend_addr = imem_addr;
      if (stale_req) begin
        stale_req = 1'b0;
      end else begin
        chk8("fetch_addr", imem_addr, model_pc);
        exp_q.push_back(model_pc);
        model_pc = model_pc + 8'd4;
      end
    end
    if_ready = ($urandom_range(99, 0) < ready_pct);
  endtask

  task automatic apply_reset(input int cycles, input bit stale);
    rst_n       = 1'b0;
    flush       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    pending     = 1'b0;
    stale_req   = 1'b0;
    use_ovr     = 1'b0;
    exp_q.delete();
    model_pc = ResetPc;
    repeat (cycles) @(posedge clk);
    #1;
    chk8("rst_pc_out", pc_out, ResetPc);
    chk1("rst_imem_req", imem_req, 1'b0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk8("rst_if_pc", if_pc, 8'h00);
    chk32("rst_if_instr", if_instr, 32'h0);
    chk1("rst_misalign", misalign_err, 1'b0);
    rst_n = 1'b1;
    if (stale) begin
      imem_rvalid     = 1'b1;
      imem_rdata      = 32'hBAD0_0BAD;
      stale_after_rst = 1'b1;
    end
  endtask

  task automatic wait_hs(input int n, input int bound, input string name);
    int start;
    int c;
    start = hs_cnt;
    c = 0;
    while ((hs_cnt - start) < n && c < bound) begin
      step();
      c++;
    end
    checks++;
    if ((hs_cnt - start) < n) begin
      errors++;
      $display("FAIL %s: got %0d instructions expected %0d within %0d cycles",
               name, hs_cnt - start, n, bound);
    end
  endtask

  // Monitor: decode handshakes against the expected queue, plus protocol rules.
  initial begin
    bit          p_hold;
    bit          p_req;
    logic [7:0]  p_pc;
    logic [7:0]  p_addr;
    logic [31:0] p_instr;
    logic [7:0]  e;
    p_hold = 1'b0;
    p_req  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_hold = 1'b0;
        p_req  = 1'b0;
        continue;
      end
      if (p_hold) begin
        chk1("hold_valid", if_valid, 1'b1);
        chk8("hold_pc", if_pc, p_pc);
        chk32("hold_instr", if_instr, p_instr);
      end
      if (p_req) begin
        chk1("req_held", imem_req, 1'b1);
        chk8("req_addr_held", imem_addr, p_addr);
      end
      if (if_valid) chk1("single_outstanding", imem_req, 1'b0);
`ifndef PC_FETCH_ALIGN_CHECK_EN
      chk1("misalign_tied", misalign_err, 1'b0);
`endif
      if (if_valid && if_ready && !flush) begin
        chk1("output_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk8("if_pc", if_pc, e);
          chk32("if_instr", if_instr, mem[e]);
        end
        hs_cnt++;
      end
      p_hold  = if_valid && !if_ready && !flush;
      p_req   = imem_req && !imem_gnt;
      p_pc    = if_pc;
      p_instr = if_instr;
      p_addr  = imem_addr;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n;
    int         base;
    logic [7:0] t;

    rst_n       = 1'b0;
    flush       = 1'b0;
    flush_pc    = 8'h00;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if_ready    = 1'b0;
    pending     = 1'b0;
    stale_req   = 1'b0;
    use_ovr     = 1'b0;
    ovr_data    = 32'h0;
    dly         = 0;
    pend_addr   = 8'h00;
    stale_after_rst = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    // Basic stream: immediate grant and response, decode always ready.
    gnt_pct = 100; max_dly = 0; fixed_dly = 0; ready_pct = 100; spur_pct = 0;
    apply_reset(3, 1'b0);
    wait_hs(3, 12, "basic_stream");

    // Decode stall: payload must hold and no new request may issue.
    ready_pct = 0;
    n = 0;
    while (!if_valid && n < 10) begin step(); n++; end
    chk1("stall_valid_seen", if_valid, 1'b1);
    repeat (5) step();
    chk1("stall_valid_kept", if_valid, 1'b1);
    ready_pct = 100;
    wait_hs(1, 4, "stall_release");

    // Randomised traffic with redirects and spurious responses.
    gnt_pct = 50; fixed_dly = -1; max_dly = 3; ready_pct = 60; spur_pct = 10;
    base = hs_cnt;
    for (int c = 0; c < 1500; c++) begin
      step();
      if (c == 700) begin
        model_flush(8'hF0);
      end else if ($urandom_range(99, 0) < 3) begin
        t = 8'($urandom) & 8'hFC;
        model_flush(t);
      end
    end
    chk1("random_progress", (hs_cnt - base) > 50, 1'b1);

    // Flush during WAIT, response arrives two cycles later and must be dropped.
    gnt_pct = 100; ready_pct = 100; spur_pct = 0; fixed_dly = 3;
    repeat (12) step();
    n = 0;
    while (!(pending && dly == 2) && n < 20) begin step(); n++; end
    chk1("wait_reached", pending && dly == 2, 1'b1);
    model_flush(8'h40);
    use_ovr  = 1'b1;
    ovr_data = 32'hDEAD_BEEF;
    dly      = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("drop_no_valid", if_valid, 1'b0);
    end
    wait_hs(1, 12, "after_flush_40");

    // Flush on the same edge as the response.
    fixed_dly = 1;
    n = 0;
    while (!(imem_rvalid && pending) && n < 20) begin step(); n++; end
    chk1("rvalid_reached", imem_rvalid && pending, 1'b1);
    model_flush(8'h80);
    step();
    chk8("flush_rvalid_pc", pc_out, 8'h80);
    chk1("flush_rvalid_valid", if_valid, 1'b0);
    chk1("flush_rvalid_req", imem_req, 1'b1);
    chk8("flush_rvalid_addr", imem_addr, 8'h80);
    wait_hs(1, 12, "after_flush_80");

    // Reset in WAIT, stale response strobes after release.
    fixed_dly = 3;
    n = 0;
    while (!(pending && !imem_req) && n < 20) begin step(); n++; end
    chk1("wait_for_reset", pending && !imem_req, 1'b1);
    apply_reset(2, 1'b1);
    wait_hs(2, 30, "after_reset");

`ifdef PC_FETCH_ALIGN_CHECK_EN
    // Misaligned redirect blocks fetching until an aligned redirect.
    ready_pct = 0;
    n = 0;
    while (!if_valid && n < 20) begin step(); n++; end
    model_flush(8'h42);
    step();
    chk1("misalign_set", misalign_err, 1'b1);
    chk1("misalign_no_req", imem_req, 1'b0);
    step();
    chk1("misalign_sticky", misalign_err, 1'b1);
    chk1("misalign_still_no_req", imem_req, 1'b0);
    model_flush(8'h44);
    step();
    chk1("misalign_cleared", misalign_err, 1'b0);
    ready_pct = 100;
    wait_hs(1, 12, "after_flush_44");
`endif

    // Drain: stop granting and let the last instruction reach decode.
    gnt_pct = 0; ready_pct = 100; spur_pct = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin step(); n++; end
    chk1("drain_empty", exp_q.size() == 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00, SHALL be the PC value loaded on reset.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-004 Port pc_out, output, 8 bits, SHALL be the current PC (pc_q), driven to the PC adder's address input.
REQ-005 Port next_pc, input, 8 bits, SHALL be the PC adder's address_out.
REQ-006 Port flush, input, 1 bit, SHALL be the redirect request; flush_pc, input, 8 bits, SHALL be the redirect target.
REQ-007 Port imem_req, output, 1 bit, SHALL be the fetch request; imem_addr, output, 8 bits, SHALL be the fetch address; imem_gnt, input, 1 bit, SHALL be the request accept.
REQ-008 Port imem_rvalid, input, 1 bit, SHALL be the response strobe; imem_rdata, input, 32 bits, SHALL be the instruction word.
REQ-009 Ports if_valid (output, 1), if_ready (input, 1), if_pc (output, 8) and if_instr (output, 32) SHALL form the valid/ready handshake to decode.
REQ-010 Port misalign_err, output, 1 bit, SHALL be the sticky misalignment flag (REQ-025).

Function
REQ-011 FSM states SHALL be IDLE, REQ, WAIT, HOLD and DROP.
REQ-012 IDLE SHALL advance to REQ unconditionally on the first clock edge after reset release.
REQ-013 On entry to REQ: capture pc_q into req_addr_q; in REQ: imem_req=1 and imem_addr=req_addr_q.
REQ-014 imem_req and imem_addr SHALL stay stable until imem_gnt=1; REQ with gnt SHALL move to WAIT.
REQ-015 WAIT with imem_rvalid=1 SHALL do all of: load if_instr=imem_rdata; load if_pc=pc_q; set if_valid=1; set pc_q=next_pc; move to HOLD.
REQ-016 HOLD SHALL keep if_valid, if_pc and if_instr stable until if_valid&&if_ready.
REQ-017 On the HOLD handshake: clear if_valid and move to REQ the same edge (one outstanding request maximum; best case one instruction per 3 cycles).
REQ-018 imem_rvalid in IDLE, REQ or HOLD SHALL be ignored.
REQ-019 flush SHALL set pc_q=flush_pc and clear if_valid, in every state, taking priority over the decode handshake.
REQ-020 Flush destination: HOLD or IDLE -> REQ; REQ without gnt -> REQ (address held per REQ-014, then DROP on gnt); REQ with gnt -> DROP; WAIT without rvalid -> DROP; WAIT with rvalid -> REQ, response discarded.
REQ-021 DROP SHALL discard the next imem_rvalid response without changing pc_q or if_* outputs, then move to REQ.
REQ-022 A flush while in DROP SHALL update pc_q and remain in DROP.
REQ-023 PC arithmetic SHALL be 8-bit unsigned; wrap-around (8'hFC to 8'h00 via next_pc) SHALL need no special handling.

Reset
REQ-024 Asserting rst_n low, including mid-transaction, SHALL force: state=IDLE, pc_q=RESET_PC, req_addr_q=RESET_PC, imem_req=0, if_valid=0, if_pc=0, if_instr=0, misalign_err=0; any in-flight response is dropped per REQ-018.

Configuration
REQ-025 With macro PC_FETCH_ALIGN_CHECK_EN defined: if REQ is entered with pc_q[1:0]!=0, set misalign_err, do not assert imem_req, and stay in REQ until flush to an aligned flush_pc (flush also clears misalign_err).
REQ-026 Without PC_FETCH_ALIGN_CHECK_EN: misalign_err SHALL be tied 0 and pc_q[1:0] SHALL be ignored for checking purposes.

Structure
REQ-027 The FSM state enum, the 32-bit instruction width and the 8-bit address width SHALL live in the shared package fetch_pkg.
REQ-028 The decode output register (if_valid/if_pc/if_instr) SHALL be one sub-module, fetch_out_reg.

Verification
REQ-029 Reset release, gnt and rvalid each 1 cycle after request, next_pc=pc+4, if_ready=1 -> imem_addr sequence 00,04,08; if_pc 00,04,08; instructions match rdata.
REQ-030 if_ready=0 for 5 cycles with if_valid=1 -> if_pc/if_instr stable, imem_req=0 throughout, no lost instruction.
REQ-031 flush to 8'h40 while in WAIT, rvalid 2 cycles later with 32'hDEADBEEF -> response dropped, next imem_addr=40, if_valid stays 0.
REQ-032 flush and imem_rvalid on the same edge -> response discarded, pc_q=flush_pc, next state REQ.
REQ-033 rst_n low during WAIT, stale rvalid after release -> outputs at reset values, first fetch address RESET_PC.
REQ-034 With PC_FETCH_ALIGN_CHECK_EN, flush to 8'h42 -> misalign_err=1, imem_req=0; then flush to 8'h44 -> misalign_err=0, fetch 44.
